// File: rtl/icache_dm_pkg.sv
// Shared bus types and encodings for the instruction fetch path.
// Core-side ibus and memory-side cbus request/response bundles.
package common;

  typedef logic [2:0] msize_t;
  typedef logic [7:0] mlen_t;
  typedef logic [1:0] axi_burst_t;

  localparam msize_t MSIZE4 = 3'd2;
  localparam msize_t MSIZE8 = 3'd3;

  localparam mlen_t MLEN1 = 8'd0;

  localparam axi_burst_t AXI_BURST_INCR = 2'd1;

  typedef struct packed {
    logic        valid;
    logic [63:0] addr;
  } ibus_req_t;

  typedef struct packed {
    logic        addr_ok;
    logic        data_ok;
    logic [31:0] data;
  } ibus_resp_t;

  typedef struct packed {
    logic        valid;
    logic        is_write;
    msize_t      size;
    logic [63:0] addr;
    logic [7:0]  strobe;
    logic [63:0] data;
    mlen_t       len;
    axi_burst_t  burst;
  } cbus_req_t;

  typedef struct packed {
    logic        ready;
    logic        last;
    logic [63:0] data;
  } cbus_resp_t;

endpackage

// File: rtl/icache_data_array.sv
// Line storage for the direct-mapped icache.
// Async read of one beat, sync write of one beat.
module icache_data_array #(
  parameter int NUM_SETS   = 16,
  parameter int LINE_BEATS = 4
) (
  input  logic                          clk,
  input  logic                          we_i,
  input  logic [$clog2(NUM_SETS)-1:0]   widx_i,
  input  logic [$clog2(LINE_BEATS)-1:0] wbeat_i,
  input  logic [63:0]                   wdata_i,
  input  logic [$clog2(NUM_SETS)-1:0]   ridx_i,
  input  logic [$clog2(LINE_BEATS)-1:0] rbeat_i,
  output logic [63:0]                   rdata_o
);

  logic [63:0] mem_q [NUM_SETS][LINE_BEATS];

  always_ff @(posedge clk) begin
    if (we_i) mem_q[widx_i][wbeat_i] <= wdata_i;
  end

  assign rdata_o = mem_q[ridx_i][rbeat_i];

endmodule

// File: rtl/icache_dm.sv
// Direct-mapped, read-only instruction cache.
// Misses refill a whole line by burst; addr[31]==0 bypasses.
module icache_dm
  import common::*;
#(
  parameter int NUM_SETS   = 16,
  parameter int LINE_BEATS = 4
) (
  input  logic       clk,
  input  logic       reset,
  input  ibus_req_t  ireq,
  output ibus_resp_t iresp,
  output cbus_req_t  creq,
  input  cbus_resp_t cresp
);

  localparam int OFF_W  = $clog2(LINE_BEATS * 8);
  localparam int IDX_W  = $clog2(NUM_SETS);
  localparam int BEAT_W = $clog2(LINE_BEATS);
  localparam int TAG_W  = 64 - OFF_W - IDX_W;

  typedef enum logic [1:0] {
    IDLE,
    REFILL,
    UNCACHED
  } state_e;

  state_e              state_q;
  logic [63:0]         addr_q;
  logic [BEAT_W-1:0]   cnt_q;
  logic [NUM_SETS-1:0] valid_q;
  logic [TAG_W-1:0]    tag_q [NUM_SETS];

  logic [IDX_W-1:0]  req_idx;
  logic [TAG_W-1:0]  req_tag;
  logic [BEAT_W-1:0] req_beat;
  logic [IDX_W-1:0]  fill_idx;
  logic [63:0]       rdata;
  logic              cacheable;
  logic              hit;
  logic              fill_we;
  logic              unc_done;

  assign req_idx   = ireq.addr[OFF_W +: IDX_W];
  assign req_tag   = ireq.addr[63 -: TAG_W];
  assign req_beat  = ireq.addr[3 +: BEAT_W];
  assign fill_idx  = addr_q[OFF_W +: IDX_W];
  assign cacheable = ireq.addr[31];

  assign hit = (state_q == IDLE) && ireq.valid && cacheable &&
               valid_q[req_idx] && (tag_q[req_idx] == req_tag);

  assign fill_we  = (state_q == REFILL) && cresp.ready;
  assign unc_done = (state_q == UNCACHED) && cresp.ready && cresp.last;

  icache_data_array #(
    .NUM_SETS   (NUM_SETS),
    .LINE_BEATS (LINE_BEATS)
  ) u_data (
    .clk     (clk),
    .we_i    (fill_we),
    .widx_i  (fill_idx),
    .wbeat_i (cnt_q),
    .wdata_i (cresp.data),
    .ridx_i  (req_idx),
    .rbeat_i (req_beat),
    .rdata_o (rdata)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      addr_q  <= '0;
      cnt_q   <= '0;
      valid_q <= '0;
    end else begin
      unique case (state_q)
        IDLE: begin
          if (ireq.valid && !cacheable) begin
            addr_q  <= ireq.addr;
            state_q <= UNCACHED;
          end else if (ireq.valid && !hit) begin
            addr_q  <= {ireq.addr[63:OFF_W], {OFF_W{1'b0}}};
            state_q <= REFILL;
          end
        end
        REFILL: begin
          if (fill_we) begin
            cnt_q <= cnt_q + 1'b1;
            if (cresp.last) begin
              cnt_q             <= '0;
              valid_q[fill_idx] <= 1'b1;
              state_q           <= IDLE;
            end
          end
        end
        UNCACHED: begin
          if (unc_done) state_q <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  // Tags need no reset: the valid bits guard them.
  always_ff @(posedge clk) begin
    if (!reset && fill_we && cresp.last)
      tag_q[fill_idx] <= addr_q[63 -: TAG_W];
  end

  always_comb begin
    iresp = '0;
    creq  = '0;
    if (hit) begin
      iresp.addr_ok = 1'b1;
      iresp.data_ok = 1'b1;
      iresp.data    = ireq.addr[2] ? rdata[63:32] : rdata[31:0];
    end
    if (unc_done) begin
      iresp.addr_ok = 1'b1;
      iresp.data_ok = 1'b1;
      iresp.data    = addr_q[2] ? cresp.data[63:32] : cresp.data[31:0];
    end
    if (state_q != IDLE) begin
      creq.valid = 1'b1;
      creq.addr  = addr_q;
      creq.burst = AXI_BURST_INCR;
      creq.size  = (state_q == REFILL) ? MSIZE8 : MSIZE4;
      creq.len   = (state_q == REFILL) ? mlen_t'(LINE_BEATS - 1) : MLEN1;
    end
  end

endmodule

// File: tb/tb_icache_dm.sv
// Bench for icache_dm: directed scenarios plus random traffic
// checked each cycle against a line-presence model over a fixed memory image.
module tb_icache_dm;
  import common::*;

  localparam int NS = 16;
  localparam int LB = 4;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  ibus_req_t  ireq = '0;
  ibus_resp_t iresp;
  cbus_req_t  creq;
  cbus_resp_t cresp = '0;

  always #5 clk = ~clk;

  icache_dm #(.NUM_SETS(NS), .LINE_BEATS(LB)) dut (
    .clk   (clk),
    .reset (reset),
    .ireq  (ireq),
    .iresp (iresp),
    .creq  (creq),
    .cresp (cresp)
  );

  int checks = 0;
  int passed = 0;

  bit          m_valid [NS];
  logic [58:0] m_line  [NS];
  bit          pend = 0;
  bit          unc = 0;
  logic [63:0] paddr = '0;
  int          beats = 0;
  int          stall = 0;
  int          rdy_pct = 100;
  int          txns = 0;
  bit          got_ok;
  bit          hs;
  logic [31:0] got_data;
  logic [63:0] last_caddr = '0;

  function automatic logic [63:0] mem64(input logic [63:0] a);
    return {a[31:0] ^ 32'hDEADBEEF, a[31:0] ^ 32'h13579BDF};
  endfunction

  function automatic logic [31:0] word_at(input logic [63:0] a);
    logic [63:0] b;
    b = mem64({a[63:3], 3'b000});
    return a[2] ? b[63:32] : b[31:0];
  endfunction

  function automatic bit present(input logic [63:0] a);
    logic [3:0] i;
    i = a[8:5];
    return m_valid[i] && (m_line[i] == a[63:5]);
  endfunction

  task automatic expect_eq(input string nm, input logic [63:0] got,
                           input logic [63:0] exp);
    checks++;
    if (got === exp) passed++;
    else $display("FAIL %s got %h expected %h", nm, got, exp);
  endtask

  task automatic check_cycle();
    ibus_resp_t er;
    cbus_req_t  ec;
    er = '0;
    ec = '0;
    if (!pend) begin
      if (ireq.valid && ireq.addr[31] && present(ireq.addr)) begin
        er.addr_ok = 1'b1;
        er.data_ok = 1'b1;
        er.data    = word_at(ireq.addr);
      end
    end else begin
      ec.valid = 1'b1;
      ec.size  = unc ? MSIZE4 : MSIZE8;
      ec.addr  = paddr;
      ec.len   = unc ? MLEN1 : mlen_t'(LB - 1);
      ec.burst = AXI_BURST_INCR;
      if (unc && cresp.ready && cresp.last) begin
        er.addr_ok = 1'b1;
        er.data_ok = 1'b1;
        er.data    = word_at(paddr);
      end
    end
    checks++;
    if (iresp === er) passed++;
    else $display("FAIL iresp t=%0t got %h expected %h", $time, iresp, er);
    checks++;
    if (creq === ec) passed++;
    else $display("FAIL creq t=%0t got %h expected %h", $time, creq, ec);
  endtask

  task automatic advance();
    logic [3:0] i;
    if (reset) begin
      pend  = 0;
      beats = 0;
      for (int k = 0; k < NS; k++) m_valid[k] = 0;
    end else if (!pend) begin
      if (ireq.valid && !ireq.addr[31]) begin
        pend  = 1;
        unc   = 1;
        paddr = ireq.addr;
        beats = 0;
      end else if (ireq.valid && !present(ireq.addr)) begin
        pend  = 1;
        unc   = 0;
        paddr = {ireq.addr[63:5], 5'b0};
        beats = 0;
      end
    end else if (cresp.ready) begin
      beats++;
      if (cresp.last) begin
        if (!unc) begin
          i = paddr[8:5];
          m_valid[i] = 1;
          m_line[i]  = paddr[63:5];
        end
        pend  = 0;
        beats = 0;
      end
    end
  endtask

  task automatic step(input bit r, input ibus_req_t q);
    logic [63:0] base;
    @(negedge clk);
    reset = r;
    ireq  = q;
    cresp = '0;
    if (pend) begin
      if (stall > 0) begin
        stall--;
      end else begin
        cresp.ready = ($urandom_range(0, 99) < rdy_pct);
      end
      base       = {paddr[63:3], 3'b000} + 64'(beats * 8);
      cresp.data = mem64(base);
      cresp.last = unc ? 1'b1 : (beats == LB - 1);
    end
    #1;
    check_cycle();
    got_ok   = iresp.data_ok;
    got_data = iresp.data;
    hs       = creq.valid && cresp.ready;
    if (creq.valid) last_caddr = creq.addr;
    if (hs && cresp.last && !r) txns++;
    advance();
  endtask

  task automatic fetch(input logic [63:0] a, output int cyc,
                       output logic [31:0] d);
    ibus_req_t q;
    q.valid = 1'b1;
    q.addr  = a;
    cyc = 0;
    do begin
      step(0, q);
      cyc++;
    end while (!got_ok && cyc < 300);
    if (!got_ok) begin
      checks++;
      $display("FAIL fetch_timeout addr %h after %0d cycles", a, cyc);
    end
    d = got_data;
  endtask

  ibus_req_t   idle_q;
  ibus_req_t   rq;
  int          c;
  int          t0;
  int          n;
  int          g;
  logic [31:0] d;

  initial begin
    idle_q = '0;
    for (int k = 0; k < NS; k++) m_valid[k] = 0;
    step(1, idle_q);
    step(1, idle_q);
    step(0, idle_q);
    expect_eq("reset_creq_valid", 64'(creq.valid), 64'd0);
    expect_eq("reset_data_ok", 64'(iresp.data_ok), 64'd0);

    t0 = txns;
    fetch(64'h8000_0000, c, d);
    expect_eq("cold_latency", 64'(c), 64'd6);
    expect_eq("cold_data", 64'(d), 64'h9357_9BDF);
    expect_eq("cold_addr", last_caddr, 64'h8000_0000);
    expect_eq("cold_txns", 64'(txns - t0), 64'd1);

    t0 = txns;
    for (int i = 1; i < 8; i++) begin
      fetch(64'h8000_0000 + 64'(4 * i), c, d);
      expect_eq("sweep_latency", 64'(c), 64'd1);
    end
    expect_eq("sweep_last_data", 64'(d), 64'h5EAD_BEF7);
    expect_eq("sweep_no_txn", 64'(txns - t0), 64'd0);

    fetch(64'h8000_0200, c, d);
    expect_eq("conflict1_latency", 64'(c), 64'd6);
    expect_eq("conflict1_data", 64'(d), 64'h9357_99DF);
    fetch(64'h8000_0000, c, d);
    expect_eq("conflict2_latency", 64'(c), 64'd6);
    expect_eq("conflict2_data", 64'(d), 64'h9357_9BDF);

    t0 = txns;
    fetch(64'h0000_1004, c, d);
    expect_eq("unc_latency", 64'(c), 64'd2);
    expect_eq("unc_data", 64'(d), 64'hDEAD_AEEF);
    expect_eq("unc_addr", last_caddr, 64'h0000_1004);
    fetch(64'h0000_1004, c, d);
    expect_eq("unc_again_latency", 64'(c), 64'd2);
    expect_eq("unc_txns", 64'(txns - t0), 64'd2);

    rq.valid = 1'b1;
    rq.addr  = 64'h8000_0040;
    n = 0;
    g = 0;
    while (n < 2 && g < 50) begin
      step(0, rq);
      if (hs) n++;
      g++;
    end
    expect_eq("midfill_beats", 64'(n), 64'd2);
    step(1, rq);
    step(0, idle_q);
    expect_eq("midfill_reset_creq", 64'(creq.valid), 64'd0);
    fetch(64'h8000_0040, c, d);
    expect_eq("refetch_latency", 64'(c), 64'd6);
    expect_eq("refetch_data", 64'(d), 64'h9357_9B9F);
    fetch(64'h8000_0000, c, d);
    expect_eq("after_reset_miss", 64'(c), 64'd6);

    stall = 10;
    fetch(64'h8000_0080, c, d);
    expect_eq("stall_latency", 64'(c), 64'd16);
    expect_eq("stall_data", 64'(d), 64'h9357_9B5F);

    rdy_pct = 60;
    for (int i = 0; i < 2000; i++) begin
      rq.valid = ($urandom_range(0, 9) < 7);
      if ($urandom_range(0, 3) == 0)
        rq.addr = {32'h0, $urandom & 32'h0000_0FFC};
      else
        rq.addr = {32'h0, 32'h8000_0000 | ($urandom & 32'h0000_07FC)};
      step($urandom_range(0, 199) == 0, rq);
    end
    step(0, idle_q);

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
